// File: rtl/dmem_resp.sv
// Data-memory responder with a req/ready handshake and LATENCY wait states.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_resp #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        WeDM,
  input  logic [63:0] doutULA,
  input  logic [63:0] dinDM,
  output logic [63:0] doutDM,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

  stateT         stateQ, stateD;
  logic [3:0]    cntQ, cntD;
  logic [AW-1:0] idxQ, idxD;
  logic          weQ, weD;
  logic [63:0]   dinQ, dinD;
  logic [63:0]   doutQ, doutD;
  logic          commit;
  logic          memWe;
  logic          bad;

  logic [63:0] mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
  logic misQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misQ <= 1'b0;
    end else if (stateQ == StIdle && req) begin
      misQ <= |doutULA[2:0];
    end
  end

  assign bad = misQ;

  logic unusedAddr;
  assign unusedAddr = ^doutULA[63:3+AW];
`else
  assign bad = 1'b0;

  // Byte offset is ignored: accesses go to the containing word.
  logic unusedAddr;
  assign unusedAddr = ^{doutULA[63:3+AW], doutULA[2:0]};
`endif

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    idxD   = idxQ;
    weD    = weQ;
    dinD   = dinQ;
    doutD  = doutQ;
    commit = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (req) begin
          stateD = StWait;
          cntD   = 4'(LATENCY);
          idxD   = doutULA[3+AW-1:3];
          weD    = WeDM;
          dinD   = dinDM;
        end
      end
      StWait: begin
        cntD = cntQ - 4'd1;
        // Final wait edge: commit the write or capture the read word.
        if (cntQ == 4'd1) begin
          stateD = StResp;
          commit = 1'b1;
          if (bad) begin
            doutD = '0;
          end else if (weQ) begin
            doutD = dinQ;
          end else begin
            doutD = mem[idxQ];
          end
        end
      end
      StResp: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
      cntQ   <= 4'd0;
      idxQ   <= '0;
      weQ    <= 1'b0;
      dinQ   <= '0;
      doutQ  <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      idxQ   <= idxD;
      weQ    <= weD;
      dinQ   <= dinD;
      doutQ  <= doutD;
    end
  end

  assign memWe = commit & weQ & ~bad;

  // Storage is never reset; a reset before the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[idxQ] <= dinQ;
    end
  end

  assign doutDM = doutQ;
  assign ready  = (stateQ == StResp);
  assign busy   = (stateQ != StIdle);
  assign err    = ready & bad;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: three instances with LATENCY 1, 2 and 3,
// a timeline model for the LATENCY=2 instance, and directed literal checks.
module tb_dmem_resp;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int LAT1 = 2;

  logic        clk;
  logic        rstV   [3];
  logic        reqV   [3];
  logic        weV    [3];
  logic [63:0] addrV  [3];
  logic [63:0] dinV   [3];
  logic [63:0] doutV  [3];
  logic        readyV [3];
  logic        busyV  [3];
  logic        errV   [3];

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  for (genvar k = 0; k < 3; k++) begin : gDut
    dmem_resp #(.DEPTH(256), .LATENCY(k + 1)) u_dut (
      .clk     (clk),
      .reset   (rstV[k]),
      .req     (reqV[k]),
      .WeDM    (weV[k]),
      .doutULA (addrV[k]),
      .dinDM   (dinV[k]),
      .doutDM  (doutV[k]),
      .ready   (readyV[k]),
      .busy    (busyV[k]),
      .err     (errV[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model for instance 1: acceptance edge t0, completion edge t0+LAT1.
  logic [63:0] memM [256];
  logic [63:0] expDout;
  int          mCyc, t0, freeAt;
  bit          mWe, mMis;
  logic [7:0]  mIdx;
  logic [63:0] mDin;

  initial forever begin
    @(posedge clk);
    if (!rstV[1]) begin
      mCyc = 0; t0 = -1; freeAt = 0; expDout = '0;
    end else begin
      mCyc++;
      if (t0 >= 0 && mCyc == t0 + LAT1) begin
        if (mMis && ALIGN) expDout = '0;
        else if (mWe) begin
          memM[mIdx] = mDin;
          expDout    = mDin;
        end else expDout = memM[mIdx];
      end
      if (mCyc >= freeAt && reqV[1]) begin
        t0     = mCyc;
        freeAt = mCyc + LAT1 + 2;
        mWe    = weV[1];
        mIdx   = addrV[1][10:3];
        mDin   = dinV[1];
        mMis   = |addrV[1][2:0];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstV[1] && mCyc > 0) begin
      bit eReady, eBusy;
      eReady = (t0 >= 0) && (mCyc == t0 + LAT1);
      eBusy  = (t0 >= 0) && (mCyc >= t0) && (mCyc <= t0 + LAT1);
      chk("model ready", 64'(readyV[1]), 64'(eReady));
      chk("model busy", 64'(busyV[1]), 64'(eBusy));
      chk("model err", 64'(errV[1]), 64'(eReady && mMis && ALIGN));
      chk("model dout", doutV[1], expDout);
    end
  end

  // Called just after a negedge; returns one negedge after the ready cycle.
  task automatic doTxn(input int k, input bit we, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output int lat, output int busyN,
                       output logic errS);
    int acc;
    bit got;
    reqV[k] = 1'b1; weV[k] = we; addrV[k] = a; dinV[k] = d;
    acc = cyc + 1;
    busyN = 0; got = 1'b0; rd = '0; errS = 1'b0; lat = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      reqV[k] = 1'b0;
      if (busyV[k]) busyN++;
      if (readyV[k]) begin
        got = 1'b1; rd = doutV[k]; errS = errV[k]; lat = cyc - acc;
      end
    end
    chk("ready seen before timeout", 64'(got), 64'(1));
    @(negedge clk);
    if (busyV[k]) busyN++;
  endtask

  initial begin
    logic [63:0] rd, a, v;
    int lat, busyN, rc0, rc1, pulses;
    logic errS;
    logic [63:0] hd0, hd1;

    for (int k = 0; k < 3; k++) begin
      rstV[k] = 1'b0; reqV[k] = 1'b0; weV[k] = 1'b0; addrV[k] = '0; dinV[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset ready", 64'(readyV[1]), 64'(0));
    chk("reset busy", 64'(busyV[1]), 64'(0));
    chk("reset err", 64'(errV[1]), 64'(0));
    chk("reset dout", doutV[1], 64'(0));
    for (int k = 0; k < 3; k++) rstV[k] = 1'b1;
    @(negedge clk);

    // Write then read, LATENCY=2.
    doTxn(1, 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, rd, lat, busyN, errS);
    chk("wr40 latency", 64'(lat), 64'(2));
    chk("wr40 busy cycles", 64'(busyN), 64'(3));
    chk("wr40 dout", rd, 64'hDEADBEEF_CAFEF00D);
    doTxn(1, 1'b0, 64'h40, 64'h0, rd, lat, busyN, errS);
    chk("rd40 dout", rd, 64'hDEADBEEF_CAFEF00D);

    // Wrap-around: index 256 aliases index 0.
    doTxn(1, 1'b1, 64'h0, 64'h1, rd, lat, busyN, errS);
    doTxn(1, 1'b0, 64'h800, 64'h0, rd, lat, busyN, errS);
    chk("wrap rd800", rd, 64'h1);

    // Preload the rest of the random-phase pool (indices 16..56 step 8).
    for (int j = 2; j < 8; j++) begin
      doTxn(1, 1'b1, 64'(j * 64), {32'hA5A5_0000 + 32'(j), $urandom}, rd, lat, busyN, errS);
    end

    // Held request: two reads of 0x40, din jitters meanwhile.
    reqV[1] = 1'b1; weV[1] = 1'b0; addrV[1] = 64'h40;
    pulses = 0; rc0 = 0; rc1 = 0; hd0 = '0; hd1 = '0;
    for (int i = 0; i < 30 && pulses < 2; i++) begin
      @(negedge clk);
      dinV[1] = {$urandom, $urandom};
      if (readyV[1]) begin
        if (pulses == 0) begin rc0 = cyc; hd0 = doutV[1]; end
        else begin rc1 = cyc; hd1 = doutV[1]; reqV[1] = 1'b0; end
        pulses++;
      end
    end
    reqV[1] = 1'b0;
    chk("held pulse count", 64'(pulses), 64'(2));
    chk("held pulse spacing", 64'(rc1 - rc0), 64'(4));
    chk("held rd0", hd0, 64'hDEADBEEF_CAFEF00D);
    chk("held rd1", hd1, 64'hDEADBEEF_CAFEF00D);
    repeat (2) @(negedge clk);

    // Misaligned write to 0x43.
    doTxn(1, 1'b1, 64'h43, 64'h1111_2222_3333_4444, rd, lat, busyN, errS);
    chk("mis err", 64'(errS), 64'(ALIGN));
    chk("mis dout", rd, ALIGN ? 64'h0 : 64'h1111_2222_3333_4444);
    chk("mis latency", 64'(lat), 64'(2));
    doTxn(1, 1'b0, 64'h40, 64'h0, rd, lat, busyN, errS);
    chk("mis rd40", rd, ALIGN ? 64'hDEADBEEF_CAFEF00D : 64'h1111_2222_3333_4444);

    // Random phase on the pool; upper address bits random to exercise wrap.
    for (int i = 0; i < 800; i++) begin
      a = {$urandom, $urandom};
      a[10:3] = 8'($urandom_range(0, 7) * 8);
      a[2:0]  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
      reqV[1]  = ($urandom_range(0, 3) != 0);
      weV[1]   = 1'($urandom_range(0, 1));
      addrV[1] = a;
      dinV[1]  = {$urandom, $urandom};
      @(negedge clk);
    end
    reqV[1] = 1'b0;
    repeat (6) @(negedge clk);

    // LATENCY=1 boundary.
    doTxn(0, 1'b1, 64'h18, 64'h77, rd, lat, busyN, errS);
    chk("lat1 wr latency", 64'(lat), 64'(1));
    doTxn(0, 1'b0, 64'h18, 64'h0, rd, lat, busyN, errS);
    chk("lat1 rd latency", 64'(lat), 64'(1));
    chk("lat1 rd busy cycles", 64'(busyN), 64'(2));
    chk("lat1 rd dout", rd, 64'h77);

    // Reset mid-operation, LATENCY=3.
    v = 64'h0123_4567_89AB_CDEF;
    doTxn(2, 1'b1, 64'h10, v, rd, lat, busyN, errS);
    chk("lat3 wr latency", 64'(lat), 64'(3));
    reqV[2] = 1'b1; weV[2] = 1'b1; addrV[2] = 64'h10; dinV[2] = 64'h55;
    @(negedge clk);
    reqV[2] = 1'b0;
    @(negedge clk);
    chk("lat3 busy before reset", 64'(busyV[2]), 64'(1));
    rstV[2] = 1'b0;
    #1;
    chk("mid reset ready", 64'(readyV[2]), 64'(0));
    chk("mid reset busy", 64'(busyV[2]), 64'(0));
    chk("mid reset err", 64'(errV[2]), 64'(0));
    chk("mid reset dout", doutV[2], 64'h0);
    repeat (2) @(negedge clk);
    rstV[2] = 1'b1;
    @(negedge clk);
    doTxn(2, 1'b0, 64'h10, 64'h0, rd, lat, busyN, errS);
    chk("lat3 rd after reset", rd, v);
    chk("lat3 rd latency", 64'(lat), 64'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
